// File: rtl/zbt_arb_pkg.sv
// rtl/zbt_arb_pkg.sv - shared constants, grant encoding and point field helpers for the ZBT0 arbiter
//
// Purpose: common definitions for the point arbiter, the point writer and the
// renderer sweep. A stored point is one ZBT word packed as {x, y, z}, ten bits
// per axis, in the low 30 bits of the 36-bit word.
// Contents:
//   ZBT_ADDR_W / ZBT_DATA_W  ZBT0 word address and data widths
//   grant_t                  grant decision of the arbiter
//   PT_*_HI / PT_*_LO        point field slices
//   pt_x/pt_y/pt_z/pt_pack   field extract and pack helpers
package zbt_arb_pkg;

  localparam int ZBT_ADDR_W = 19;
  localparam int ZBT_DATA_W = 36;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2,
    GNT_FWR  = 2'd3
  } grant_t;

  localparam int PT_X_HI = 29;
  localparam int PT_X_LO = 20;
  localparam int PT_Y_HI = 19;
  localparam int PT_Y_LO = 10;
  localparam int PT_Z_HI = 9;
  localparam int PT_Z_LO = 0;

  function automatic logic [9:0] pt_x(input logic [ZBT_DATA_W-1:0] w);
    return w[PT_X_HI:PT_X_LO];
  endfunction

  function automatic logic [9:0] pt_y(input logic [ZBT_DATA_W-1:0] w);
    return w[PT_Y_HI:PT_Y_LO];
  endfunction

  function automatic logic [9:0] pt_z(input logic [ZBT_DATA_W-1:0] w);
    return w[PT_Z_HI:PT_Z_LO];
  endfunction

  function automatic logic [ZBT_DATA_W-1:0] pt_pack(input logic [9:0] x,
                                                    input logic [9:0] y,
                                                    input logic [9:0] z);
    return {6'd0, x, y, z};
  endfunction

endpackage

// File: rtl/zbt_read_valid_pipe.sv
// rtl/zbt_read_valid_pipe.sv - shift register turning a read grant into a latency-aligned valid strobe
//
// Purpose: delays the read-issued bit by DEPTH cycles so the valid strobe lines
// up with data returning from the ZBT controller pipeline.
// Ports:
//   clk        system clock
//   reset      synchronous active-high; flushes every stage
//   grant_bit  1 in the cycle a read address is on the ZBT bus
//   valid      grant_bit delayed by DEPTH cycles
module zbt_read_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_bit,
  output logic valid
);

  logic [DEPTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage <= '0;
    end else begin
      stage[0] <= grant_bit;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign valid = stage[DEPTH-1];

endmodule

// File: rtl/zbt_point_arbiter.sv
// rtl/zbt_point_arbiter.sv - ZBT0 bank arbiter between the point writer and the renderer read sweep
//
// Purpose: issues at most one ZBT operation per cycle. Reads have fixed
// priority; a starvation counter forces a writer grant after STARVE_LIMIT
// consecutive denied writer cycles. Read data is passed straight through with a
// valid strobe aligned to READ_LATENCY.
// Optional build macro: ZBT_POINT_COUNT_EN enables the stored point counter;
// without it point_count is tied to all ones and clear_count is ignored.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   rd_req/rd_addr/rd_ack           renderer read request and issue pulse
//   rd_data/rd_valid                read data (combinational) and its strobe
//   wr_req/wr_addr/wr_data/wr_ack   writer request and issue pulse
//   clear_count/point_count         point counter clear and value
//   zbt_addr/zbt_we/zbt_write_data  registered command to the ZBT controller
//   zbt_read_data                   data returned by the ZBT controller
module zbt_point_arbiter
  import zbt_arb_pkg::*;
#(
  parameter int ADDR_W       = ZBT_ADDR_W,
  parameter int DATA_W       = ZBT_DATA_W,
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clear_count,
  output logic [ADDR_W-1:0] point_count,
  output logic [ADDR_W-1:0] zbt_addr,
  output logic              zbt_we,
  output logic [DATA_W-1:0] zbt_write_data,
  input  logic [DATA_W-1:0] zbt_read_data
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  grant_t     gnt;
  logic       wr_grant;
  logic [7:0] starve_cnt;

  // Grant decision from the requests sampled at this edge. The forced write
  // only triggers once the writer has been denied LIMIT cycles in a row.
  always_comb begin
    gnt = GNT_IDLE;
    if (wr_req && (starve_cnt == LIMIT)) begin
      gnt = GNT_FWR;
    end else if (rd_req) begin
      gnt = GNT_RD;
    end else if (wr_req) begin
      gnt = GNT_WR;
    end
  end

  assign wr_grant = (gnt == GNT_WR) || (gnt == GNT_FWR);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ack         <= 1'b0;
      wr_ack         <= 1'b0;
      zbt_we         <= 1'b0;
      zbt_addr       <= '0;
      zbt_write_data <= '0;
      starve_cnt     <= 8'd0;
    end else begin
      rd_ack <= (gnt == GNT_RD);
      wr_ack <= wr_grant;
      zbt_we <= wr_grant;
      // Address and write data hold through idle cycles.
      if (gnt == GNT_RD) begin
        zbt_addr <= rd_addr;
      end else if (wr_grant) begin
        zbt_addr       <= wr_addr;
        zbt_write_data <= wr_data;
      end
      if (!wr_req || wr_grant) begin
        starve_cnt <= 8'd0;
      end else if (starve_cnt < LIMIT) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

  // rd_ack is high exactly while the read address sits on zbt_addr, so it is
  // the grant bit taken from the address cycle.
  zbt_read_valid_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_valid_pipe (
    .clk      (clk),
    .reset    (reset),
    .grant_bit(rd_ack),
    .valid    (rd_valid)
  );

  assign rd_data = zbt_read_data;

`ifdef ZBT_POINT_COUNT_EN
  logic [ADDR_W-1:0] count_q;

  // Count is one past the highest written address; the top address cannot
  // be represented as +1, so it saturates at all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_count) begin
      count_q <= '0;
    end else if (wr_grant && (wr_addr >= count_q)) begin
      count_q <= (&wr_addr) ? wr_addr : wr_addr + ADDR_W'(1);
    end
  end

  assign point_count = count_q;
`else
  logic unused_clear;
  assign unused_clear = clear_count;
  assign point_count  = '1;
`endif

endmodule

// File: tb/tb_zbt_point_arbiter.sv
// tb/tb_zbt_point_arbiter.sv - self-checking bench for zbt_point_arbiter
module tb_zbt_point_arbiter;

  logic        clk;
  logic        reset;
  logic        rd_req;
  logic [18:0] rd_addr;
  logic        rd_ack;
  logic [35:0] rd_data;
  logic        rd_valid;
  logic        wr_req;
  logic [18:0] wr_addr;
  logic [35:0] wr_data;
  logic        wr_ack;
  logic        clear_count;
  logic [18:0] point_count;
  logic [18:0] zbt_addr;
  logic        zbt_we;
  logic [35:0] zbt_write_data;
  logic [35:0] zbt_read_data;

  int total = 0;
  int bad   = 0;

  zbt_point_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_ack        (rd_ack),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .clear_count   (clear_count),
    .point_count   (point_count),
    .zbt_addr      (zbt_addr),
    .zbt_we        (zbt_we),
    .zbt_write_data(zbt_write_data),
    .zbt_read_data (zbt_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ZBT model: contents are a fixed function of address, data returns two
  // cycles after the address is presented.
  function automatic logic [35:0] mem_word(input logic [18:0] a);
    return {17'd0, a} * 36'h0_0001_0001 + 36'h9_0000_0003;
  endfunction

  logic [18:0] ap0, ap1;
  always @(posedge clk) begin
    ap0 <= zbt_addr;
    ap1 <= ap0;
  end
  assign zbt_read_data = mem_word(ap1);

  function automatic logic [18:0] exp_pc(input logic [18:0] with_count);
`ifdef ZBT_POINT_COUNT_EN
    return with_count;
`else
    return 19'h7FFFF;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; clear_count = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rd_req;
    logic [18:0] rd_addr;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [35:0] wr_data;
    logic        e_rd_ack;
    logic        e_wr_ack;
    logic        e_we;
    logic [18:0] e_addr;
    logic [35:0] e_wdata;
    logic [18:0] e_pc;
  } vec_t;

  vec_t vt[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, vals, maxwait, wait_cnt;
    int ack_cyc[10];
    logic exp_w;

    //        rd  rd_addr    wr  wr_addr    wr_data          rda wra we  addr       wdata            pc
    vt[0] = '{0, 19'h00000, 0, 19'h00000, 36'h000000000, 0, 0, 0, 19'h00000, 36'h000000000, 19'h00000};
    vt[1] = '{0, 19'h00000, 1, 19'h00005, 36'h123456789, 0, 1, 1, 19'h00005, 36'h123456789, 19'h00006};
    vt[2] = '{0, 19'h00000, 0, 19'h00000, 36'h000000000, 0, 0, 0, 19'h00005, 36'h123456789, 19'h00006};
    vt[3] = '{1, 19'h00007, 0, 19'h00000, 36'h000000000, 1, 0, 0, 19'h00007, 36'h123456789, 19'h00006};
    vt[4] = '{1, 19'h7FFFF, 1, 19'h00010, 36'hABCDEF012, 1, 0, 0, 19'h7FFFF, 36'h123456789, 19'h00006};
    vt[5] = '{0, 19'h00000, 1, 19'h00010, 36'hABCDEF012, 0, 1, 1, 19'h00010, 36'hABCDEF012, 19'h00011};
    vt[6] = '{0, 19'h00000, 1, 19'h7FFFF, 36'hFFFFFFFFF, 0, 1, 1, 19'h7FFFF, 36'hFFFFFFFFF, 19'h7FFFF};
    vt[7] = '{0, 19'h00000, 0, 19'h00000, 36'h000000000, 0, 0, 0, 19'h7FFFF, 36'hFFFFFFFFF, 19'h7FFFF};

    do_reset();
    chk("reset_rd_ack", rd_ack, 0);
    chk("reset_wr_ack", wr_ack, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_zbt_we", zbt_we, 0);
    chk("reset_zbt_addr", zbt_addr, 0);
    chk("reset_zbt_wdata", zbt_write_data, 0);
    chk("reset_point_count", point_count, exp_pc(19'h0));

    // Table vectors: one edge each, outputs checked after the edge.
    for (int i = 0; i < 8; i++) begin
      rd_req = vt[i].rd_req; rd_addr = vt[i].rd_addr;
      wr_req = vt[i].wr_req; wr_addr = vt[i].wr_addr; wr_data = vt[i].wr_data;
      step();
      chk($sformatf("vec%0d_rd_ack", i), rd_ack, vt[i].e_rd_ack);
      chk($sformatf("vec%0d_wr_ack", i), wr_ack, vt[i].e_wr_ack);
      chk($sformatf("vec%0d_zbt_we", i), zbt_we, vt[i].e_we);
      chk($sformatf("vec%0d_zbt_addr", i), zbt_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_zbt_wdata", i), zbt_write_data, vt[i].e_wdata);
      chk($sformatf("vec%0d_point_count", i), point_count, exp_pc(vt[i].e_pc));
    end
    idle_inputs();
    step();

    // Read stream 0..9, back-to-back, valid two cycles after each ack.
    do_reset();
    acks = 0; vals = 0;
    rd_addr = 19'd0; rd_req = 1'b1;
    for (int cyc = 0; cyc < 40 && vals < 10; cyc++) begin
      step();
      if (rd_valid) begin
        if (vals < acks) begin
          chk("stream_rd_data", rd_data, mem_word(19'(vals)));
          chk("stream_valid_latency", cyc - ack_cyc[vals], 2);
        end else begin
          chk("stream_spurious_valid", rd_valid, 0);
        end
        vals++;
      end
      if (rd_ack) begin
        if (acks < 10) begin
          chk("stream_zbt_addr", zbt_addr, acks);
          chk("stream_zbt_we", zbt_we, 0);
          ack_cyc[acks] = cyc;
          if (acks > 0) chk("stream_back_to_back", cyc - ack_cyc[acks-1], 1);
        end
        acks++;
        if (acks < 10) rd_addr = 19'(acks);
        else rd_req = 1'b0;
      end
    end
    chk("stream_ack_count", acks, 10);
    chk("stream_valid_count", vals, 10);
    step();
    step();

    // Starvation: both requesters held high, writer forced every 9th cycle.
    do_reset();
    rd_req = 1'b1; rd_addr = 19'd1;
    wr_req = 1'b1; wr_addr = 19'd2; wr_data = 36'h0DEADBEEF;
    maxwait = 0; wait_cnt = 0;
    for (int i = 0; i < 27; i++) begin
      step();
      exp_w = ((i % 9) == 8);
      chk($sformatf("starve_wr_ack_c%0d", i), wr_ack, exp_w);
      chk($sformatf("starve_rd_ack_c%0d", i), rd_ack, !exp_w);
      wait_cnt++;
      if (wr_ack) begin
        if (wait_cnt > maxwait) maxwait = wait_cnt;
        wait_cnt = 0;
      end
    end
    chk("starve_max_wait_le_9", (maxwait <= 9), 1);
    idle_inputs();
    step();
    step();
    step();

    // Point count: 3 -> 4, 10 -> 11, 7 -> 11, clear wins over write to 20.
    do_reset();
    wr_req = 1'b1; wr_addr = 19'd3; wr_data = 36'h1;
    step();
    chk("pc_after_3", point_count, exp_pc(19'd4));
    wr_addr = 19'd10;
    step();
    chk("pc_after_10", point_count, exp_pc(19'd11));
    wr_addr = 19'd7;
    step();
    chk("pc_after_7", point_count, exp_pc(19'd11));
    wr_addr = 19'd20; clear_count = 1'b1;
    step();
    chk("pc_clear_beats_write", point_count, exp_pc(19'd0));
    chk("pc_clear_write_ack", wr_ack, 1);
    chk("pc_clear_write_addr", zbt_addr, 20);
    idle_inputs();
    step();
    chk("pc_idle_hold", point_count, exp_pc(19'd0));

    // Reset one cycle after a read ack: the in-flight valid is flushed.
    do_reset();
    rd_req = 1'b1; rd_addr = 19'd4;
    step();
    chk("midrst_rd_ack", rd_ack, 1);
    rd_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_rd_ack_clr", rd_ack, 0);
    chk("midrst_zbt_addr", zbt_addr, 0);
    chk("midrst_zbt_we", zbt_we, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midrst_no_valid_c%0d", i), rd_valid, 0);
    end

    // Reset right after a write grant drops zbt_we on the next edge.
    wr_req = 1'b1; wr_addr = 19'd9; wr_data = 36'h55;
    step();
    chk("wrrst_we_before", zbt_we, 1);
    wr_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("wrrst_we_after", zbt_we, 0);
    chk("wrrst_wr_ack", wr_ack, 0);
    chk("wrrst_wdata", zbt_write_data, 0);
    chk("wrrst_point_count", point_count, exp_pc(19'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zbt_point_arbiter.md
Name: zbt_point_arbiter

Overview:
- Shares the single ZBT0 bank between two requesters:
  - the point writer, which stores scanned points packed as {x,y,z} in 36-bit words;
  - the renderer read sweep, which streams points back out for display.
- Issues at most one bus operation per cycle.
- Read has fixed priority; a starvation counter guarantees writer progress.
- Returns read data with a valid strobe aligned to ZBT pipeline latency, and optionally tracks the stored point count that bounds the renderer sweep.

Parameters:
- ADDR_W, 19, ZBT word address width.
- DATA_W, 36, ZBT word width.
- READ_LATENCY, 2, cycles from zbt_addr presented to zbt_read_data valid (range 1..4).
- STARVE_LIMIT, 8, consecutive denied writer-request cycles before the writer is forced a grant (range 1..255).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- rd_req, input, 1, renderer requests a read.
- rd_addr, input, ADDR_W, read address.
- rd_ack, output, 1, read request sampled last edge was issued.
- rd_data, output, DATA_W, read data; combinational pass-through of zbt_read_data.
- rd_valid, output, 1, rd_data is valid this cycle.
- wr_req, input, 1, writer requests a write.
- wr_addr, input, ADDR_W, write address.
- wr_data, input, DATA_W, write data.
- wr_ack, output, 1, write request sampled last edge was issued.
- clear_count, input, 1, zero the point count.
- point_count, output, ADDR_W, stored point count (one past highest written address).
- zbt_addr, output, ADDR_W, address to ZBT controller.
- zbt_we, output, 1, write enable to ZBT controller.
- zbt_write_data, output, DATA_W, write data to ZBT controller.
- zbt_read_data, input, DATA_W, data from ZBT controller.

Behaviour:
- All outputs except rd_data are registered.
- Reset values: rd_ack=0, wr_ack=0, rd_valid=0, zbt_we=0, zbt_addr=0, zbt_write_data=0, point_count=0, starve counter=0, valid pipe all 0.
- Each edge, a grant is decided from the sampled requests:
  - FORCE_WR: wr_req and starve_cnt == STARVE_LIMIT.
  - else RD: rd_req.
  - else WR: wr_req.
  - else IDLE.
- Grant effects, registered on the same edge:
  - RD: zbt_addr<=rd_addr, zbt_we<=0, rd_ack<=1.
  - WR or FORCE_WR: zbt_addr<=wr_addr, zbt_write_data<=wr_data, zbt_we<=1, wr_ack<=1.
  - IDLE: zbt_we<=0, both acks 0, zbt_addr and zbt_write_data hold.
- Acks are single-cycle pulses.
- Handshake:
  - A requester holds req/addr/data stable until it sees ack.
  - In the ack cycle it presents its next request or deasserts.
  - The arbiter treats req sampled during an ack cycle as a new request.
  - This gives one transfer per cycle back-to-back.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when wr_req=1 and the writer is not granted.
  - Clears on any writer grant or when wr_req=0.
- rd_valid is a READ_LATENCY-deep shift of the RD-grant bit, taken from the cycle zbt_addr is driven. rd_valid therefore rises exactly READ_LATENCY cycles after rd_ack. Read ordering is preserved.
- Simultaneous rd_req and wr_req below the limit: read wins; writer waits.
- Reset mid-operation: valid pipe is flushed, so no rd_valid for in-flight reads. zbt_we drops on the next edge. Requesters re-present after reset.
- Width rule: addresses are not wrapped or checked; the full ADDR_W range is passed through.

Optional Feature:
- Macro: ZBT_POINT_COUNT_EN.
- With the macro:
  - On every writer grant, if wr_addr >= point_count, then point_count <= wr_addr+1, saturating at 2^ADDR_W-1.
  - clear_count=1 sets point_count to 0 and has priority over a same-cycle write update.
- Without the macro: point_count is tied to 2^ADDR_W-1 and clear_count is ignored.

Decomposition:
- Shared package zbt_arb_pkg holds:
  - ADDR_W and DATA_W constants;
  - grant encoding (GNT_IDLE=0, GNT_RD=1, GNT_WR=2, GNT_FWR=3);
  - point field slices (X=[29:20], Y=[19:10], Z=[9:0]), shared with renderer and writer.
- One sub-module, zbt_read_valid_pipe: parameterised shift register producing rd_valid, with synchronous clear on reset.

Test Plan:
- Read stream: rd_req held high with rd_addr stepping 0..9 on each ack, wr_req=0 -> 10 rd_ack pulses on consecutive cycles; rd_valid 2 cycles after each ack; rd_data equals model memory at addresses 0..9 in order.
- Single write: wr_req with addr 0x00005 and data 0x123456789 -> next cycle zbt_we=1, zbt_addr=5, zbt_write_data=0x123456789, wr_ack=1 for one cycle.
- Starvation: rd_req and wr_req both held high continuously, STARVE_LIMIT=8 -> 8 read grants, then 1 forced write grant, repeating every 9 cycles; writer never waits more than 9 cycles.
- Point count (macro on): writes to addresses 3, 10, 7 -> point_count 4, 11, 11; clear_count asserted with a same-cycle write to 20 -> point_count=0.
- Reset mid-read: reset asserted 1 cycle after an rd_ack -> no rd_valid for that read; after reset all outputs at reset values and zbt_we=0.
- Macro off: point_count=0x7FFFF constant regardless of writes or clear_count.
